// File: rtl/conv_seq_pkg.sv
//----------------------------------------------------------------------------
// conv_seq_pkg : shared types and helpers for the conversion sequencer
// Revision 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package conv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  localparam int ADC_SLOT = 0;

  function automatic int slot_idx_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
//----------------------------------------------------------------------------
// phase_timer : loadable down-counter, expire flags the last phase cycle
// Revision 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A phase loaded with N reports expiry during its Nth cycle
  assign expire = (count_q == W'(1));

endmodule

`default_nettype wire

// File: rtl/conv_sequencer.sv
//----------------------------------------------------------------------------
// conv_sequencer : ADC slot then NUM_DAC DAC slots, each settle + active
// Revision 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NUM_DAC    = 2,
  parameter int MUX_W      = 19,
  parameter int DWELL_W    = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic                           clk_10MHz,
  input  logic                           reset,
  input  logic                           locked,
  input  logic                           start,
  input  logic                           continuous,
  input  logic                           stop,
  input  logic [DWELL_W-1:0]             dwell,
  input  logic [(NUM_DAC+1)*MUX_W-1:0]   mux_cfg,
  output logic                           adc_control,
  output logic [NUM_DAC-1:0]             dac_control,
  output logic [MUX_W-1:0]               mux_signals,
  output logic                           busy,
  output logic                           done,
  output logic                           abort_err
);

  localparam int NUM_SLOTS = NUM_DAC + 1;
  localparam int SLOT_W    = slot_idx_w(NUM_SLOTS);
  localparam int SETTLE_W  = $clog2(SETTLE_CYC + 1);
  localparam int TIMER_W   = (DWELL_W > SETTLE_W) ? DWELL_W : SETTLE_W;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  seq_state_e                     state_q, state_d;
  logic [SLOT_W-1:0]              slot_q, slot_d;
  logic                           cont_q, cont_d;
  logic [DWELL_W-1:0]             dwell_q, dwell_d;
  logic [NUM_SLOTS*MUX_W-1:0]     cfg_q, cfg_d;
  logic                           stop_pending_q, stop_pending_d;
  logic [NUM_SLOTS-1:0]           strobe_q, strobe_d;
  logic [MUX_W-1:0]               mux_q, mux_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           abort_q, abort_d;

  logic                           tmr_load;
  logic [TIMER_W-1:0]             tmr_value;
  logic                           tmr_expire;
  logic [DWELL_W-1:0]             dwell_eff;
  logic [SLOT_W-1:0]              slot_nxt;

  assign dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign slot_nxt  = slot_q + SLOT_W'(1);

  phase_timer #(.W(TIMER_W)) u_phase_timer (
    .clk    (clk_10MHz),
    .rst    (reset),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    cont_d         = cont_q;
    dwell_d        = dwell_q;
    cfg_d          = cfg_q;
    stop_pending_d = stop_pending_q;
    abort_d        = abort_q;
    strobe_d       = '0;
    mux_d          = '0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    tmr_load       = 1'b0;
    tmr_value      = '0;

    case (state_q)
      IDLE: begin
        stop_pending_d = 1'b0;
        if (start && locked) begin
          cont_d    = continuous;
          dwell_d   = dwell;
          cfg_d     = mux_cfg;
          abort_d   = 1'b0;
          state_d   = SETTLE;
          slot_d    = SLOT_W'(ADC_SLOT);
          busy_d    = 1'b1;
          mux_d     = mux_cfg[ADC_SLOT*MUX_W +: MUX_W];
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(SETTLE_CYC);
        end
      end

      SETTLE, ACTIVE: begin
        if (!locked) begin
          state_d        = IDLE;
          abort_d        = 1'b1;
          stop_pending_d = 1'b0;
        end else begin
          stop_pending_d = stop_pending_q | stop;
          busy_d         = 1'b1;
          mux_d          = cfg_q[int'(slot_q)*MUX_W +: MUX_W];
          if (state_q == SETTLE) begin
            if (tmr_expire) begin
              state_d   = ACTIVE;
              strobe_d  = NUM_SLOTS'(1) << slot_q;
              tmr_load  = 1'b1;
              tmr_value = TIMER_W'(dwell_eff);
            end
          end else if (!tmr_expire) begin
            strobe_d = NUM_SLOTS'(1) << slot_q;
          end else if (slot_q != LAST_SLOT) begin
            state_d   = SETTLE;
            slot_d    = slot_nxt;
            mux_d     = cfg_q[int'(slot_nxt)*MUX_W +: MUX_W];
            tmr_load  = 1'b1;
            tmr_value = TIMER_W'(SETTLE_CYC);
          end else if (cont_q && !stop_pending_q) begin
            // Continuous mode wraps straight back to the ADC slot
            state_d   = SETTLE;
            slot_d    = SLOT_W'(ADC_SLOT);
            mux_d     = cfg_q[ADC_SLOT*MUX_W +: MUX_W];
            tmr_load  = 1'b1;
            tmr_value = TIMER_W'(SETTLE_CYC);
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            mux_d   = '0;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        state_d        = IDLE;
        stop_pending_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_10MHz) begin
    if (reset) begin
      state_q        <= IDLE;
      slot_q         <= '0;
      cont_q         <= 1'b0;
      dwell_q        <= '0;
      cfg_q          <= '0;
      stop_pending_q <= 1'b0;
      strobe_q       <= '0;
      mux_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      abort_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      cont_q         <= cont_d;
      dwell_q        <= dwell_d;
      cfg_q          <= cfg_d;
      stop_pending_q <= stop_pending_d;
      strobe_q       <= strobe_d;
      mux_q          <= mux_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      abort_q        <= abort_d;
    end
  end

  assign adc_control = strobe_q[ADC_SLOT];
  assign dac_control = strobe_q[NUM_SLOTS-1:1];
  assign mux_signals = mux_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign abort_err   = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_sequencer.sv
//----------------------------------------------------------------------------
// tb_conv_sequencer : scoreboard bench for conv_sequencer (two configurations)
// Revision 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_conv_sequencer;

  logic        clk = 1'b0;
  logic        reset, locked, start, continuous, stop;
  logic [7:0]  dwell;
  logic [56:0] mux_cfg;
  logic [39:0] mux_cfg_b;

  logic        adc_control, busy, done, abort_err;
  logic [1:0]  dac_control;
  logic [18:0] mux_signals;

  logic        adc_b, busy_b, done_b, abort_b;
  logic [3:0]  dac_b;
  logic [7:0]  mux_b;

  logic [24:0] qa[$];
  logic [15:0] qb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #50 clk = ~clk;

  conv_sequencer dut (
    .clk_10MHz   (clk),
    .reset       (reset),
    .locked      (locked),
    .start       (start),
    .continuous  (continuous),
    .stop        (stop),
    .dwell       (dwell),
    .mux_cfg     (mux_cfg),
    .adc_control (adc_control),
    .dac_control (dac_control),
    .mux_signals (mux_signals),
    .busy        (busy),
    .done        (done),
    .abort_err   (abort_err)
  );

  conv_sequencer #(.NUM_DAC(4), .MUX_W(8), .DWELL_W(8), .SETTLE_CYC(1)) dut4 (
    .clk_10MHz   (clk),
    .reset       (reset),
    .locked      (locked),
    .start       (start),
    .continuous  (continuous),
    .stop        (stop),
    .dwell       (dwell),
    .mux_cfg     (mux_cfg_b),
    .adc_control (adc_b),
    .dac_control (dac_b),
    .mux_signals (mux_b),
    .busy        (busy_b),
    .done        (done_b),
    .abort_err   (abort_b)
  );

  // Expected word: {abort, done, busy, dac, adc, mux}
  task automatic push_pass_a(input logic [56:0] cfg, input int dw, input int limit);
    int cnt = 0;
    int act = (dw == 0) ? 1 : dw;
    logic [1:0] dc;
    for (int k = 0; k < 3; k++) begin
      dc = (k == 0) ? 2'b00 : (2'b01 << (k - 1));
      for (int s = 0; s < 2; s++)
        if (cnt < limit) begin qa.push_back({3'b001, 2'b00, 1'b0, cfg[k*19 +: 19]}); cnt++; end
      for (int d = 0; d < act; d++)
        if (cnt < limit) begin qa.push_back({3'b001, dc, k == 0, cfg[k*19 +: 19]}); cnt++; end
    end
  endtask

  task automatic push_idle_a(input int n, input logic ab);
    for (int i = 0; i < n; i++) qa.push_back({ab, 24'd0});
  endtask

  task automatic push_done_a();
    qa.push_back({3'b010, 22'd0});
  endtask

  task automatic next_a(output logic [24:0] got, output logic [24:0] exp);
    @(negedge clk);
    got = {abort_err, done, busy, dac_control, adc_control, mux_signals};
    if (qa.size() > 0) exp = qa.pop_front();
    else exp = 'x;
  endtask

  task automatic next_b(output logic [15:0] got, output logic [15:0] exp);
    @(negedge clk);
    got = {abort_b, done_b, busy_b, dac_b, adc_b, mux_b};
    if (qb.size() > 0) exp = qb.pop_front();
    else exp = 'x;
  endtask

  task automatic test_reset();
    logic [24:0] got, exp;
    reset = 1'b1; locked = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    dwell = 8'd0; mux_cfg = '0; mux_cfg_b = '0;
    repeat (2) @(negedge clk);
    qa.delete();
    push_idle_a(1, 1'b0);
    next_a(got, exp); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_state: got %h expected %h", got, exp); end
    reset = 1'b0; start = 1'b1; locked = 1'b0;
    push_idle_a(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next_a(got, exp); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL start_unlocked cycle %0d: got %h expected %h", i, got, exp); end
    end
    start = 1'b0; locked = 1'b1;
  endtask

  task automatic test_single_shot();
    logic [24:0] got, exp;
    logic [56:0] cfg = {19'h5A5A5, 19'h1C3C3, 19'h7F00F};
    mux_cfg = cfg; dwell = 8'd4; continuous = 1'b0; start = 1'b1;
    push_pass_a(cfg, 4, 99); push_done_a(); push_idle_a(2, 1'b0);
    for (int i = 0; i < 21; i++) begin
      next_a(got, exp); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL single_shot cycle %0d: got %h expected %h", i, got, exp); end
      start   = (i == 5 || i == 18);
      stop    = (i == 7);
      dwell   = (i == 5) ? 8'd1 : 8'd4;
      mux_cfg = (i >= 5) ? ~cfg : cfg;
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_dwell_zero();
    logic [24:0] got, exp;
    logic [56:0] cfg = {19'h00111, 19'h22200, 19'h4000F};
    mux_cfg = cfg; dwell = 8'd0; continuous = 1'b0; start = 1'b1;
    push_pass_a(cfg, 0, 99); push_done_a(); push_idle_a(1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      next_a(got, exp); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL dwell_zero cycle %0d: got %h expected %h", i, got, exp); end
      start = 1'b0;
    end
  endtask

  task automatic test_continuous();
    logic [24:0] got, exp;
    logic [56:0] cfg = {19'h12345, 19'h6789A, 19'h0BCDE};
    mux_cfg = cfg; dwell = 8'd1; continuous = 1'b1; start = 1'b1;
    push_pass_a(cfg, 1, 99); push_pass_a(cfg, 1, 99); push_done_a(); push_idle_a(2, 1'b0);
    for (int i = 0; i < 21; i++) begin
      next_a(got, exp); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL continuous cycle %0d: got %h expected %h", i, got, exp); end
      start = (i == 5);
      if (i == 3) continuous = 1'b0;
      if (i == 5) mux_cfg = '0;
      stop = (i == 12);
    end
    start = 1'b0; stop = 1'b0; continuous = 1'b0;
  endtask

  task automatic test_abort();
    logic [24:0] got, exp;
    logic [56:0] cfg = {19'h70707, 19'h0F0F0, 19'h33333};
    mux_cfg = cfg; dwell = 8'd4; continuous = 1'b0; start = 1'b1;
    push_pass_a(cfg, 4, 10); push_idle_a(3, 1'b1);
    push_pass_a(cfg, 4, 99); push_done_a(); push_idle_a(1, 1'b0);
    for (int i = 0; i < 33; i++) begin
      next_a(got, exp); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL abort cycle %0d: got %h expected %h", i, got, exp); end
      start  = (i == 12);
      locked = (i < 9 || i >= 11);
    end
    start = 1'b0; locked = 1'b1;
  endtask

  task automatic test_abort_last();
    logic [24:0] got, exp;
    logic [56:0] cfg = {19'h11111, 19'h22222, 19'h44444};
    mux_cfg = cfg; dwell = 8'd1; continuous = 1'b0; start = 1'b1;
    push_pass_a(cfg, 1, 99); push_idle_a(2, 1'b1);
    for (int i = 0; i < 11; i++) begin
      next_a(got, exp); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL abort_last cycle %0d: got %h expected %h", i, got, exp); end
      start  = 1'b0;
      locked = (i != 8);
    end
    locked = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [24:0] got, exp;
    logic [56:0] cfg = {19'h00001, 19'h00002, 19'h7FFFF};
    mux_cfg = cfg; dwell = 8'd2; continuous = 1'b0; start = 1'b1;
    push_pass_a(cfg, 2, 1); push_idle_a(5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      next_a(got, exp); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_mid cycle %0d: got %h expected %h", i, got, exp); end
      reset  = (i == 0);
      start  = (i != 0);
      locked = (i == 0);
    end
    start = 1'b0; locked = 1'b1;
  endtask

  task automatic test_wide();
    logic [15:0] got, exp;
    logic [39:0] cfg = {8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C};
    logic [3:0]  dc;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    qb.delete();
    for (int k = 0; k < 5; k++) begin
      dc = (k == 0) ? 4'b0000 : (4'b0001 << (k - 1));
      qb.push_back({3'b001, 4'b0000, 1'b0, cfg[k*8 +: 8]});
      for (int d = 0; d < 2; d++) qb.push_back({3'b001, dc, k == 0, cfg[k*8 +: 8]});
    end
    qb.push_back({3'b010, 13'd0});
    qb.push_back(16'd0);
    mux_cfg_b = cfg; dwell = 8'd2; continuous = 1'b0; start = 1'b1;
    for (int i = 0; i < 17; i++) begin
      next_b(got, exp); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL wide cycle %0d: got %h expected %h", i, got, exp); end
      start = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_dwell_zero();
    test_continuous();
    test_abort();
    test_abort_last();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
Parametrised successor to the single-ADC idle/acquire sequencer. On a start request it steps through one ADC slot followed by NUM_DAC DAC slots. Each slot runs a settle phase, where the slot's mux pattern is driven, and then an active phase, where that slot's control strobe is held high. It supports single-shot and continuous modes, a programmable dwell, graceful stop, and abort on PLL lock loss. It sits between the 10 MHz clock domain controller and the ADC/DAC/analog-mux front end.

Parameters:
NUM_DAC, 2, number of DAC slots after the ADC slot (1..8); NUM_SLOTS = NUM_DAC+1
MUX_W, 19, width of the analog mux control word
DWELL_W, 8, width of the active-phase dwell count
SETTLE_CYC, 2, settle-phase length in cycles (>=1)

Ports:
clk_10MHz  in  1  sole clock
reset  in  1  synchronous, active-high reset
locked  in  1  PLL lock; must be 1 to start and to stay running
start  in  1  start request, sampled every cycle
continuous  in  1  mode select, latched at accepted start; 1 = repeat passes
stop  in  1  request to end after the current pass (continuous mode)
dwell  in  DWELL_W  active-phase length in cycles, latched at accepted start; 0 is treated as 1
mux_cfg  in  NUM_SLOTS*MUX_W  per-slot mux pattern, slot k at bits [k*MUX_W +: MUX_W], latched at accepted start
adc_control  out  1  high during ADC-slot active phase
dac_control  out  NUM_DAC  bit j high during DAC slot j+1 active phase
mux_signals  out  MUX_W  current slot's mux pattern during settle/active; 0 otherwise
busy  out  1  high in SETTLE/ACTIVE
done  out  1  one-cycle pulse at the normal end of the sequence
abort_err  out  1  sticky; set on lock loss while busy

Behaviour:
- All outputs registered. Reset (priority over everything) -> state IDLE, all outputs 0, stop_pending=0, abort_err=0.
- States: IDLE, SETTLE, ACTIVE, DONE. Slot index 0..NUM_SLOTS-1 (0 = ADC).
- IDLE: start=1 and locked=1 at cycle t -> accept; latch continuous/dwell/mux_cfg; clear abort_err. At t+1: SETTLE slot 0, busy=1, mux_signals=cfg[0]. start with locked=0 is ignored.
- SETTLE lasts exactly SETTLE_CYC cycles, with controls 0 -> ACTIVE on the same slot.
- ACTIVE lasts max(dwell,1) cycles; exactly one control bit high (the slot's bit); mux_signals unchanged from SETTLE.
- End of ACTIVE, slot < NUM_SLOTS-1 -> SETTLE for slot+1, with no gap cycle.
- End of ACTIVE on the last slot: if continuous=1 and stop_pending=0 -> SETTLE slot 0; otherwise -> DONE.
- DONE: one cycle with done=1, busy=0, all controls 0, mux_signals 0 -> IDLE. start during DONE is ignored.
- Single-shot latency: start at t -> done at t+1+NUM_SLOTS*(SETTLE_CYC+max(dwell,1)). With defaults and dwell=4, done is at t+19.
- start while busy is ignored; latched settings never change mid-run.
- stop=1 in any busy cycle sets stop_pending. stop_pending clears on entry to IDLE. stop in single-shot mode has no effect on timing.
- locked=0 in any busy cycle -> next cycle IDLE, all controls/mux/busy 0, abort_err=1, no done pulse.
- locked=0 in the same cycle as the final ACTIVE cycle: abort wins.
- Timer is a down-counter loaded on phase entry; no wrap, because dwell=0 is saturated to 1.
- Controls are one-hot or zero at all times; never two strobes high.

Decomposition:
- Package conv_seq_pkg holds the state enum (IDLE/SETTLE/ACTIVE/DONE), a slot-index width function clog2(NUM_SLOTS), and a localparam for ADC slot index 0.
- Sub-module phase_timer: loadable down-counter (load, value, expire) shared by SETTLE and ACTIVE.

Test Plan:
- Defaults, dwell=4, continuous=0, start at t -> adc_control high t+3..t+6, dac_control[0] high t+9..t+12, dac_control[1] high t+15..t+18, done at t+19, mux_signals = cfg[k] during slot k.
- dwell=0 -> each active phase is 1 cycle; done at t+1+3*3 = t+10.
- continuous=1, stop pulsed during the second pass's slot 1 -> second pass completes, done pulses once, then IDLE; start pulses mid-run are ignored.
- locked dropped during DAC slot 1 ACTIVE -> next cycle all outputs 0, abort_err=1, no done; a new start with locked=1 clears abort_err.
- reset asserted mid-SETTLE -> next cycle all outputs 0; start held with locked=0 -> stays IDLE.
- NUM_DAC=4, MUX_W=8, SETTLE_CYC=1, dwell=2 -> five slots of 3 cycles each, done at t+16, strobes one-hot throughout.
